// File: rtl/conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_scheduler
// Description : Walks every valid output center of an image and, for each
//               center, loads it into the allocator and then streams the
//               window pixel coordinates with their filter-weight indices.
//               One full image pass per start; honours allocator back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_scheduler #(
    parameter int COORD_W = 8,
    parameter int FCNT_W  = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] img_w,
    input  logic [COORD_W-1:0] img_h,
    input  logic [COORD_W-1:0] img_d,
    input  logic [2:0]         filter_dim,
    output logic [COORD_W-1:0] center_x,
    output logic [COORD_W-1:0] center_y,
    output logic               center_write_enable,
    output logic [COORD_W-1:0] issue_x,
    output logic [COORD_W-1:0] issue_y,
    output logic [COORD_W-1:0] issue_z,
    output logic [FCNT_W-1:0]  filter_issue_counter,
    output logic               issue_valid,
    input  logic               issue_blocked,
    input  logic               filter_blocked,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    // Latched pass configuration
    logic [COORD_W-1:0] rad;
    logic [COORD_W-1:0] cx_max;
    logic [COORD_W-1:0] cy_max;
    logic [COORD_W-1:0] z_last;

    // Current center and window position
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [COORD_W-1:0] ix;
    logic [COORD_W-1:0] iy;
    logic [COORD_W-1:0] iz;
    logic [FCNT_W-1:0]  fcnt;
    logic               err_q;

    logic [COORD_W-1:0] dim_ext;
    logic [COORD_W-1:0] rad_new;
    logic               cfg_empty;
    logic               cfg_ok;
    logic               accept;
    logic               x_end;
    logic               y_end;
    logic               last_elem;
    logic               more_centers;

    assign dim_ext   = {{(COORD_W-3){1'b0}}, filter_dim};
    assign rad_new   = {{(COORD_W-2){1'b0}}, filter_dim[2:1]};
    // An image smaller than the filter, or with no depth, has no valid center
    assign cfg_empty = (img_w < dim_ext) | (img_h < dim_ext) | (img_d == '0);
    assign cfg_ok    = (state == S_IDLE) & start & filter_dim[0] & ~cfg_empty;

    assign accept       = (state == S_ISSUE) & ~issue_blocked & ~filter_blocked;
    assign x_end        = (ix == cx + rad);
    assign y_end        = (iy == cy + rad);
    assign last_elem    = x_end & y_end & (iz == z_last);
    assign more_centers = (cx < cx_max) | (cy < cy_max);

    assign center_x             = cx;
    assign center_y             = cy;
    assign issue_x              = ix;
    assign issue_y              = iy;
    assign issue_z              = iz;
    assign filter_issue_counter = fcnt;
    assign err                  = err_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-derived strobes
    always_comb begin
        state_nx            = state;
        center_write_enable = 1'b0;
        issue_valid         = 1'b0;
        busy                = 1'b1;
        done                = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && filter_dim[0]) begin
                    state_nx = cfg_empty ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                center_write_enable = 1'b1;
                state_nx            = S_ISSUE;
            end
            S_ISSUE: begin
                issue_valid = 1'b1;
                if (accept && last_elem) begin
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                state_nx = more_centers ? S_LOAD : S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Configuration latch, center stepping and window/weight counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rad    <= '0;
            cx_max <= '0;
            cy_max <= '0;
            z_last <= '0;
            cx     <= '0;
            cy     <= '0;
            ix     <= '0;
            iy     <= '0;
            iz     <= '0;
            fcnt   <= '0;
            err_q  <= 1'b0;
        end else begin
            // Even filter sides (including 0) have no center pixel
            err_q <= (state == S_IDLE) & start & ~filter_dim[0];

            if (cfg_ok) begin
                rad    <= rad_new;
                cx_max <= img_w - COORD_W'(1) - rad_new;
                cy_max <= img_h - COORD_W'(1) - rad_new;
                z_last <= img_d - COORD_W'(1);
                cx     <= rad_new;
                cy     <= rad_new;
            end

            if (state == S_LOAD) begin
                ix   <= cx - rad;
                iy   <= cy - rad;
                iz   <= '0;
                fcnt <= '0;
            end

            // The final accept leaves the counters alone; LOAD reinitialises them
            if (accept && !last_elem) begin
                fcnt <= fcnt + FCNT_W'(1);
                if (!x_end) begin
                    ix <= ix + COORD_W'(1);
                end else begin
                    ix <= cx - rad;
                    if (!y_end) begin
                        iy <= iy + COORD_W'(1);
                    end else begin
                        iy <= cy - rad;
                        iz <= iz + COORD_W'(1);
                    end
                end
            end

            if (state == S_NEXT) begin
                if (cx < cx_max) begin
                    cx <= cx + COORD_W'(1);
                end else if (cy < cy_max) begin
                    cx <= rad;
                    cy <= cy + COORD_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_scheduler
// Description : Self-checking bench for conv_scheduler. A reference model
//               enumerates the expected centers and window elements for each
//               pass; observed center writes and accepts are compared in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_scheduler;

    localparam int CW = 8;
    localparam int FW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] img_w = '0;
    logic [CW-1:0] img_h = '0;
    logic [CW-1:0] img_d = '0;
    logic [2:0]    filter_dim = '0;
    logic [CW-1:0] center_x;
    logic [CW-1:0] center_y;
    logic          center_write_enable;
    logic [CW-1:0] issue_x;
    logic [CW-1:0] issue_y;
    logic [CW-1:0] issue_z;
    logic [FW-1:0] filter_issue_counter;
    logic          issue_valid;
    logic          issue_blocked = 1'b0;
    logic          filter_blocked = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    conv_scheduler #(.COORD_W(CW), .FCNT_W(FW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .img_w                (img_w),
        .img_h                (img_h),
        .img_d                (img_d),
        .filter_dim           (filter_dim),
        .center_x             (center_x),
        .center_y             (center_y),
        .center_write_enable  (center_write_enable),
        .issue_x              (issue_x),
        .issue_y              (issue_y),
        .issue_z              (issue_z),
        .filter_issue_counter (filter_issue_counter),
        .issue_valid          (issue_valid),
        .issue_blocked        (issue_blocked),
        .filter_blocked       (filter_blocked),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        longint x;
        longint y;
        longint z;
        longint c;
    } elem_t;

    elem_t  exp_c[$];
    elem_t  exp_i[$];
    int     ci;
    int     ii;
    int     stall_mode;
    int     bcnt;
    int     n_total = 0;
    int     n_bad   = 0;
    bit     hold_pend;
    longint p_elem;
    longint p_cen;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint all_outputs();
        return longint'({center_x, center_y, center_write_enable, issue_x, issue_y,
                         issue_z, filter_issue_counter, issue_valid, busy, done, err});
    endfunction

    // Compare center writes / accepts in order and check hold-while-stalled
    task automatic monitor();
        bit acc;
        acc = issue_valid && !issue_blocked && !filter_blocked;
        if (hold_pend) begin
            check_val("hold_valid", longint'(issue_valid), 1);
            check_val("hold_elem", longint'({issue_x, issue_y, issue_z, filter_issue_counter}), p_elem);
            check_val("hold_center", longint'({center_x, center_y}), p_cen);
        end
        if (center_write_enable) begin
            check_val("cwe_with_valid", longint'(issue_valid), 0);
            if (ci < exp_c.size()) begin
                check_val("center_x", longint'(center_x), exp_c[ci].x);
                check_val("center_y", longint'(center_y), exp_c[ci].y);
            end else begin
                check_val("center_extra", longint'(ci + 1), longint'(exp_c.size()));
            end
            ci++;
        end
        if (acc) begin
            if (ii < exp_i.size()) begin
                check_val("issue_x", longint'(issue_x), exp_i[ii].x);
                check_val("issue_y", longint'(issue_y), exp_i[ii].y);
                check_val("issue_z", longint'(issue_z), exp_i[ii].z);
                check_val("fcnt", longint'(filter_issue_counter), exp_i[ii].c);
            end else begin
                check_val("accept_extra", longint'(ii + 1), longint'(exp_i.size()));
            end
            ii++;
        end
        hold_pend = issue_valid && !acc;
        p_elem    = longint'({issue_x, issue_y, issue_z, filter_issue_counter});
        p_cen     = longint'({center_x, center_y});
    endtask

    // One clock: drive inputs just after the edge, sample on the falling edge
    task automatic cycle_step(input bit st);
        @(posedge clk);
        #1;
        start = st;
        case (stall_mode)
            1: begin
                issue_blocked  = ~issue_blocked;
                filter_blocked = (bcnt >= 8 && bcnt < 13);
            end
            2: begin
                issue_blocked  = ($urandom % 4) == 0;
                filter_blocked = ($urandom % 5) == 0;
            end
            default: begin
                issue_blocked  = 1'b0;
                filter_blocked = 1'b0;
            end
        endcase
        bcnt++;
        @(negedge clk);
        monitor();
    endtask

    task automatic build_model(input int w, input int h, input int d, input int dim);
        int r;
        int k;
        exp_c.delete();
        exp_i.delete();
        ci = 0;
        ii = 0;
        hold_pend = 1'b0;
        r = dim / 2;
        if (w >= dim && h >= dim && d > 0) begin
            for (int cy = r; cy <= h - 1 - r; cy++) begin
                for (int cx = r; cx <= w - 1 - r; cx++) begin
                    exp_c.push_back('{cx, cy, 0, 0});
                    k = 0;
                    for (int z = 0; z < d; z++)
                        for (int y = cy - r; y <= cy + r; y++)
                            for (int x = cx - r; x <= cx + r; x++) begin
                                exp_i.push_back('{x, y, z, k});
                                k++;
                            end
                end
            end
        end
    endtask

    task automatic start_pass(input int w, input int h, input int d, input int dim, input int smode);
        build_model(w, h, d, dim);
        stall_mode = smode;
        bcnt       = 0;
        img_w      = CW'(w);
        img_h      = CW'(h);
        img_d      = CW'(d);
        filter_dim = 3'(dim);
        cycle_step(1'b1);
        cycle_step(1'b0);
    endtask

    task automatic run_pass(input int w, input int h, input int d, input int dim,
                            input int smode, input bit restart);
        int     n;
        longint exp_cyc;
        start_pass(w, h, d, dim, smode);
        exp_cyc = longint'(exp_c.size()) * longint'(2 + dim * dim * d) + 1;
        n = 1;
        forever begin
            check_val("busy_in_pass", longint'(busy), 1);
            if (done) break;
            if (n >= 20000) begin
                check_val("done_timeout", 0, 1);
                break;
            end
            if (restart) begin
                img_w      = CW'($urandom);
                img_h      = CW'($urandom);
                img_d      = CW'($urandom);
                filter_dim = 3'($urandom);
            end
            cycle_step(restart && n < 40 && ($urandom % 2) == 1);
            n++;
        end
        if (smode == 0 && n < 20000) check_val("done_cycle", longint'(n), exp_cyc);
        stall_mode = 0;
        cycle_step(1'b0);
        check_val("done_one_cycle", longint'(done), 0);
        check_val("idle_after_done", longint'(busy), 0);
        check_val("center_count", longint'(ci), longint'(exp_c.size()));
        check_val("accept_count", longint'(ii), longint'(exp_i.size()));
    endtask

    task automatic err_test(input int dim);
        build_model(0, 0, 0, 1);
        stall_mode = 0;
        img_w      = 5;
        img_h      = 5;
        img_d      = 1;
        filter_dim = 3'(dim);
        cycle_step(1'b1);
        cycle_step(1'b0);
        check_val("err_pulse", longint'(err), 1);
        check_val("err_busy", longint'(busy), 0);
        cycle_step(1'b0);
        check_val("err_one_cycle", longint'(err), 0);
        check_val("err_no_done", longint'(done), 0);
        check_val("err_busy2", longint'(busy), 0);
        check_val("err_no_center", longint'(ci), 0);
    endtask

    int dims[4] = '{1, 3, 5, 7};

    initial begin
        // Asynchronous reset: outputs clear without a clock edge
        #3 rst = 1'b0;
        #1 check_val("reset_outputs", all_outputs(), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_val("post_reset_outputs", all_outputs(), 0);

        run_pass(5, 5, 1, 3, 0, 1'b0);
        run_pass(4, 3, 2, 3, 0, 1'b0);
        run_pass(5, 5, 2, 3, 1, 1'b0);
        err_test(4);
        err_test(0);
        err_test(6);
        run_pass(2, 2, 1, 3, 0, 1'b0);
        run_pass(2, 2, 1, 1, 0, 1'b0);

        // Abort during the second center's window
        start_pass(5, 5, 1, 3, 0);
        for (int n = 0; n < 200 && ci < 2; n++) cycle_step(1'b0);
        check_val("reached_center2", longint'(ci), 2);
        repeat (3) cycle_step(1'b0);
        check_val("in_issue_before_rst", longint'(issue_valid), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_val("async_reset_outputs", all_outputs(), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run_pass(5, 5, 1, 3, 0, 1'b0);

        // Extra starts and config churn while busy must not disturb the pass
        run_pass(5, 5, 1, 3, 0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            run_pass($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 3),
                     dims[$urandom % 4], (t % 2 == 0) ? 2 : 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
